// File: rtl/regfile_pkg.sv
// Shared defaults, address-width helper and packed vector types for the
// multi-port register file.
package regfile_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;
  localparam int DEF_NREAD = 2;

  // A two-entry file still needs one address bit.
  function automatic int aw_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_AW = aw_of(DEF_NREGS);

  typedef logic [DEF_NREAD*DEF_AW-1:0]   addr_vec_t;
  typedef logic [DEF_NREAD*DEF_XLEN-1:0] data_vec_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by a lock and
// cleared by the matching writeback, plus per-read-port blocked flags.
module regfile_scoreboard #(
  parameter int NREGS    = 32,
  parameter int NREAD    = 2,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_wr_en,
  input  logic [AW-1:0]       i_wr_addr,
  input  logic                i_lock_en,
  input  logic [AW-1:0]       i_lock_addr,
  input  logic [NREAD*AW-1:0] i_rs_addr,
  output logic [NREGS-1:0]    o_busy,
  output logic [NREAD-1:0]    o_blocked
);

  logic [NREGS-1:0] r_busy;
  logic             w_wr_clr;
  logic             w_lock_set;

  assign w_wr_clr   = i_wr_en   && !(ZERO_REG != 0 && i_wr_addr   == '0);
  assign w_lock_set = i_lock_en && !(ZERO_REG != 0 && i_lock_addr == '0);

  // The set comes last so a new producer supersedes a landing writeback.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      if (w_wr_clr)   r_busy[i_wr_addr]   <= 1'b0;
      if (w_lock_set) r_busy[i_lock_addr] <= 1'b1;
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_port
    logic [AW-1:0] w_a;
    assign w_a = i_rs_addr[k*AW +: AW];
    assign o_blocked[k] = r_busy[w_a] &&
                          !(BYPASS != 0 && i_wr_en && i_wr_addr == w_a);
  end

  assign o_busy = r_busy;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with registered read data, write-to-read
// bypass, hardwired zero register and a pending-write read stall.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = DEF_XLEN,
  parameter int NREGS    = DEF_NREGS,
  parameter int NREAD    = DEF_NREAD,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = aw_of(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_req,
  output logic                  rd_ready,
  input  logic [NREAD*AW-1:0]   rs_addr,
  output logic [NREAD*XLEN-1:0] rs_data,
  output logic                  rs_valid,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  input  logic                  lock_en,
  input  logic [AW-1:0]         lock_addr,
  output logic [NREGS-1:0]      busy
);

  // Handshake: a read is accepted on a rising edge where rd_req && rd_ready;
  // rs_valid pulses for exactly one cycle after each accept and rs_data is
  // only updated then. rd_ready is independent of rd_req.

  logic [XLEN-1:0]       r_regs [NREGS];
  logic [NREAD*XLEN-1:0] r_rs_data;
  logic                  r_rs_valid;
  logic [NREAD*XLEN-1:0] w_rd_next;
  logic [NREAD-1:0]      w_blocked;
  logic [NREGS-1:0]      w_busy;
  logic                  w_accept;
  logic                  w_wr_live;

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .NREAD    (NREAD),
    .AW       (AW),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .i_wr_en     (wr_en),
    .i_wr_addr   (wr_addr),
    .i_lock_en   (lock_en),
    .i_lock_addr (lock_addr),
    .i_rs_addr   (rs_addr),
    .o_busy      (w_busy),
    .o_blocked   (w_blocked)
  );

  assign w_wr_live = wr_en && !(ZERO_REG != 0 && wr_addr == '0);
  assign rd_ready  = ~|w_blocked;
  assign w_accept  = rd_req && rd_ready;

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0] w_a;
    assign w_a = rs_addr[k*AW +: AW];
    assign w_rd_next[k*XLEN +: XLEN] =
      (ZERO_REG != 0 && w_a == '0)                ? '0      :
      (BYPASS != 0 && wr_en && wr_addr == w_a)    ? wr_data :
                                                    r_regs[w_a];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_wr_live) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rs_valid <= 1'b0;
      r_rs_data  <= '0;
    end else begin
      r_rs_valid <= w_accept;
      if (w_accept) r_rs_data <= w_rd_next;
    end
  end

  assign rs_data  = r_rs_data;
  assign rs_valid = r_rs_valid;
  assign busy     = w_busy;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default, no-bypass and 4-port/64-bit builds,
// with read results checked from an expected queue per instance.
module tb_regfile_mp;
  import regfile_pkg::*;

  logic clk;
  logic rst;

  // Shared stimulus for the 2-port 32-bit builds (bypass on / off)
  logic        rd_req;
  addr_vec_t   rs_addr;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        lock_en;
  logic [4:0]  lock_addr;

  logic        a_rd_ready, b_rd_ready;
  data_vec_t   a_rs_data,  b_rs_data;
  logic        a_rs_valid, b_rs_valid;
  logic [31:0] a_busy,     b_busy;

  // 4-port, 64-bit, 16-register build
  logic         c_rd_req;
  logic [15:0]  c_rs_addr;
  logic         c_wr_en;
  logic [3:0]   c_wr_addr;
  logic [63:0]  c_wr_data;
  logic         c_lock_en;
  logic [3:0]   c_lock_addr;
  logic         c_rd_ready;
  logic [255:0] c_rs_data;
  logic         c_rs_valid;
  logic [15:0]  c_busy;

  regfile_mp #(.BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_ready(a_rd_ready),
    .rs_addr(rs_addr), .rs_data(a_rs_data), .rs_valid(a_rs_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .lock_en(lock_en), .lock_addr(lock_addr), .busy(a_busy)
  );

  regfile_mp #(.BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_ready(b_rd_ready),
    .rs_addr(rs_addr), .rs_data(b_rs_data), .rs_valid(b_rs_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .lock_en(lock_en), .lock_addr(lock_addr), .busy(b_busy)
  );

  regfile_mp #(.XLEN(64), .NREGS(16), .NREAD(4)) dut_c (
    .clk(clk), .rst(rst), .rd_req(c_rd_req), .rd_ready(c_rd_ready),
    .rs_addr(c_rs_addr), .rs_data(c_rs_data), .rs_valid(c_rs_valid),
    .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data),
    .lock_en(c_lock_en), .lock_addr(c_lock_addr), .busy(c_busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [255:0] exp_a_q[$];
  logic [255:0] exp_b_q[$];
  logic [255:0] exp_c_q[$];
  logic         pend_a, pend_b, pend_c;
  int           n_vec;
  int           n_err;
  logic [63:0]  cm [16];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and compare whatever the DUTs present afterwards.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("a_rs_valid", a_rs_valid, pend_a);
    chk("b_rs_valid", b_rs_valid, pend_b);
    chk("c_rs_valid", c_rs_valid, pend_c);
    if (pend_a && exp_a_q.size() > 0) chk("a_rs_data", a_rs_data, exp_a_q.pop_front());
    if (pend_b && exp_b_q.size() > 0) chk("b_rs_data", b_rs_data, exp_b_q.pop_front());
    if (pend_c && exp_c_q.size() > 0) chk("c_rs_data", c_rs_data, exp_c_q.pop_front());
    pend_a = 1'b0;
    pend_b = 1'b0;
    pend_c = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic req, input logic [4:0] a1, input logic [4:0] a0,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic le, input logic [4:0] la);
    rd_req    = req;
    rs_addr   = {a1, a0};
    wr_en     = we;
    wr_addr   = wa;
    wr_data   = wd;
    lock_en   = le;
    lock_addr = la;
  endtask

  task automatic expect_ab(input logic rdy_a, input logic [63:0] da,
                           input logic rdy_b, input logic [63:0] db);
    #1;
    chk("a_rd_ready", a_rd_ready, rdy_a);
    chk("b_rd_ready", b_rd_ready, rdy_b);
    if (rd_req && rdy_a) begin exp_a_q.push_back({192'h0, da}); pend_a = 1'b1; end
    if (rd_req && rdy_b) begin exp_b_q.push_back({192'h0, db}); pend_b = 1'b1; end
  endtask

  task automatic expect_c(input logic rdy, input logic [255:0] d);
    #1;
    chk("c_rd_ready", c_rd_ready, rdy);
    if (c_rd_req && rdy) begin exp_c_q.push_back(d); pend_c = 1'b1; end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [63:0]  v;
    logic [3:0]   ad;
    logic [255:0] e;

    n_vec = 0; n_err = 0;
    pend_a = 1'b0; pend_b = 1'b0; pend_c = 1'b0;
    for (int i = 0; i < 16; i++) cm[i] = 64'h0;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    c_rd_req = 0; c_rs_addr = '0; c_wr_en = 0; c_wr_addr = '0; c_wr_data = '0;
    c_lock_en = 0; c_lock_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_valid", a_rs_valid, 1'b0);
    chk("rst_a_data",  a_rs_data,  64'h0);
    chk("rst_a_busy",  a_busy,     32'h0);
    chk("rst_b_busy",  b_busy,     32'h0);
    chk("rst_c_valid", c_rs_valid, 1'b0);
    chk("rst_c_busy",  c_busy,     16'h0);
    rst = 1'b0;

    // Read x1,x2 after reset
    drive(1, 2, 1, 0, 0, 0, 0, 0);   expect_ab(1, 64'h0, 1, 64'h0); tick();
    // Write x5, then read {x0,x5}
    drive(0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0); expect_ab(1, 64'h0, 1, 64'h0); tick();
    drive(1, 0, 5, 0, 0, 0, 0, 0);
    expect_ab(1, {32'h0, 32'hDEADBEEF}, 1, {32'h0, 32'hDEADBEEF}); tick();
    // Write x0 while reading it, then read x0 again
    drive(1, 5, 0, 1, 0, 32'h1234, 0, 0);
    expect_ab(1, {32'hDEADBEEF, 32'h0}, 1, {32'hDEADBEEF, 32'h0}); tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0);   expect_ab(1, 64'h0, 1, 64'h0); tick();
    // Same-cycle write/read of x7: forwarded only with bypass
    drive(1, 5, 7, 1, 7, 32'hA5A5A5A5, 0, 0);
    expect_ab(1, {32'hDEADBEEF, 32'hA5A5A5A5}, 1, {32'hDEADBEEF, 32'h0}); tick();
    drive(1, 7, 7, 0, 0, 0, 0, 0);
    expect_ab(1, {2{32'hA5A5A5A5}}, 1, {2{32'hA5A5A5A5}}); tick();
    // Lock x3, hold a read of {x4,x3} through the stall
    drive(0, 0, 0, 0, 0, 0, 1, 3);   expect_ab(1, 64'h0, 1, 64'h0); tick();
    chk("lock3_a_busy", a_busy, 32'h8);
    chk("lock3_b_busy", b_busy, 32'h8);
    drive(1, 4, 3, 0, 0, 0, 0, 0);
    repeat (3) begin expect_ab(0, 64'h0, 0, 64'h0); tick(); end
    drive(1, 4, 3, 1, 3, 32'h55, 0, 0);
    expect_ab(1, {32'h0, 32'h55}, 0, 64'h0); tick();
    chk("wb3_a_busy", a_busy, 32'h0);
    chk("wb3_b_busy", b_busy, 32'h0);
    drive(1, 4, 3, 0, 0, 0, 0, 0);
    expect_ab(1, {32'h0, 32'h55}, 1, {32'h0, 32'h55}); tick();
    // Lock and write x9 together while reading it: read sees pre-edge busy
    drive(1, 5, 9, 1, 9, 32'h77, 1, 9);
    expect_ab(1, {32'hDEADBEEF, 32'h77}, 1, {32'hDEADBEEF, 32'h0}); tick();
    chk("lockwr9_a_busy", a_busy, 32'h200);
    chk("lockwr9_b_busy", b_busy, 32'h200);
    drive(1, 9, 9, 0, 0, 0, 0, 0);
    repeat (2) begin expect_ab(0, 64'h0, 0, 64'h0); tick(); end
    drive(1, 9, 9, 1, 9, 32'h99, 0, 0);
    expect_ab(1, {2{32'h99}}, 0, 64'h0); tick();
    drive(1, 9, 9, 0, 0, 0, 0, 0);
    expect_ab(1, {2{32'h99}}, 1, {2{32'h99}}); tick();
    // Reset during an accepted read: no valid, data and registers cleared
    drive(1, 9, 5, 0, 0, 0, 0, 0);
    #1;
    chk("prerst_a_ready", a_rd_ready, 1'b1);
    rst = 1'b1;
    tick();
    chk("rst_rd_a_data", a_rs_data, 64'h0);
    chk("rst_rd_b_data", b_rs_data, 64'h0);
    rst = 1'b0;
    // Lock of x0 is ignored
    drive(0, 0, 0, 0, 0, 0, 1, 0);   expect_ab(1, 64'h0, 1, 64'h0); tick();
    chk("lock0_a_busy", a_busy, 32'h0);
    drive(1, 9, 5, 0, 0, 0, 0, 0);  expect_ab(1, 64'h0, 1, 64'h0); tick();
    // Reset during a stall drops the read
    drive(0, 0, 0, 0, 0, 0, 1, 3);   expect_ab(1, 64'h0, 1, 64'h0); tick();
    drive(1, 4, 3, 0, 0, 0, 0, 0);  expect_ab(0, 64'h0, 0, 64'h0);
    rst = 1'b1;
    tick();
    chk("rst_stall_a_busy", a_busy, 32'h0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // 4-port build: fill registers, then packed/duplicated and streaming reads
    for (int i = 0; i < 16; i++) begin
      v = {$urandom(), $urandom()};
      c_wr_en = 1'b1; c_wr_addr = 4'(i); c_wr_data = v;
      if (i != 0) cm[i] = v;
      expect_c(1, '0); tick();
    end
    c_wr_en = 1'b0;
    c_rd_req = 1'b1;
    c_rs_addr = {4'd0, 4'd15, 4'd1, 4'd1};
    expect_c(1, {64'h0, cm[15], cm[1], cm[1]}); tick();
    for (int n = 0; n < 10; n++) begin
      for (int k = 0; k < 4; k++) begin
        ad = 4'($urandom_range(0, 15));
        c_rs_addr[k*4 +: 4] = ad;
        e[k*64 +: 64] = (ad == 4'd0) ? 64'h0 : cm[ad];
      end
      expect_c(1, e); tick();
    end
    c_rd_req = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised, synchronous multi-read-port integer register file for the core; next generation of the strobe-driven register bank.
- Clocked on one edge with async reset, N read ports behind a request/ready handshake, registered read data with a valid pulse, write-to-read bypass, hardwired-zero register 0.
- Adds a per-register pending-write scoreboard: reads of registers with an outstanding producer stall until the writeback lands.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers (power of two, >= 2); AW = clog2(NREGS).
- NREAD, 2, number of read ports (1..4).
- ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes and locks.
- BYPASS, 1, 1 = a same-cycle write is forwarded to an accepted read of that address.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- rd_req  in  1  read request; all source addresses valid while high.
- rd_ready  out  1  read can be accepted this cycle (combinational).
- rs_addr  in  NREAD*AW  packed source addresses; port k = bits [k*AW +: AW].
- rs_data  out  NREAD*XLEN  packed registered read data.
- rs_valid  out  1  one-cycle pulse: rs_data holds the result of the read accepted last cycle.
- wr_en  in  1  writeback strobe.
- wr_addr  in  AW  writeback address.
- wr_data  in  XLEN  writeback data.
- lock_en  in  1  mark lock_addr as having a pending producer.
- lock_addr  in  AW  register to mark pending.
- busy  out  NREGS  current scoreboard bits (debug/hazard visibility).

Behaviour:
- Reset (async, while rst=1): all registers = 0, busy = 0, rs_data = 0, rs_valid = 0. Reset mid-stall drops the pending read; no rs_valid follows.
- Write: at posedge with wr_en=1, reg[wr_addr] <= wr_data and busy[wr_addr] <= 0. With ZERO_REG=1 and wr_addr=0, nothing changes.
- Lock: at posedge with lock_en=1, busy[lock_addr] <= 1. Ignored for address 0 when ZERO_REG=1.
- Lock and write to the same address in the same cycle: the lock wins and busy stays 1, because a new producer supersedes the old one. The write data is still stored.
- Port k is blocked when busy[rs_addr[k]]=1, unless BYPASS=1, wr_en=1 and wr_addr==rs_addr[k].
- rd_ready = no port blocked. It does not depend on rd_req.
- Accept = rd_req & rd_ready. The requester holds rd_req and rs_addr stable until accepted.
- Latency: accept in cycle T -> rs_valid=1 and rs_data valid in cycle T+1. rs_valid is 0 in every cycle not following an accept.
- rs_data keeps its last value when no read is accepted.
- Read data per port:
  - 0 if ZERO_REG=1 and address is 0;
  - else wr_data if BYPASS=1, wr_en=1 and wr_addr matches;
  - else reg[addr] (pre-edge value).
- With BYPASS=0, a same-cycle write is not visible; the old value is returned. A blocked read then waits one extra cycle for busy to clear.
- Duplicate addresses across ports are legal and all return identical data.
- A lock issued in the same cycle as an accepted read of that address does not affect that read (pre-edge busy is used).
- Back-to-back accepts are allowed every cycle. No internal FSM beyond the scoreboard; the stall is purely rd_ready=0.

Decomposition:
- Package regfile_pkg holds:
  - default XLEN/NREGS/NREAD;
  - the AW derivation function;
  - a typedef for the packed address and data vectors.
- One natural sub-module, regfile_scoreboard. It holds the busy vector, set/clear priority, zero-register masking, and the per-port blocked/bypass-qualified outputs.
- The data array, read muxing and output registers stay in regfile_mp.

Test Plan:
- Reset, then read x1,x2 -> rd_ready=1; next cycle rs_valid=1, rs_data = {0,0}. Assert rst during an accepted read -> no rs_valid.
- Write x5=0xDEADBEEF, next cycle read {x5,x0} -> {0xDEADBEEF, 0}. Write x0=0x1234, read x0 -> 0.
- Write x7=0xA5A5A5A5 and read x7 in the same cycle (BYPASS=1) -> 0xA5A5A5A5 next cycle. Repeat with BYPASS=0 -> old value 0.
- lock x3, then hold rd_req on {x3,x4} -> rd_ready=0 for 3 cycles. Then write x3=0x55 -> accepted that cycle (bypass), rs_data port0 = 0x55, busy[3]=0.
- Same-cycle lock x9 and write x9=0x77 -> busy[9]=1 and reg holds 0x77. A read of x9 stalls until the next write to x9.
- NREAD=4, XLEN=64, NREGS=16: reads {x1,x1,x15,x0} after writes -> correct duplicated and packed data. Continuous rd_req -> rs_valid high every cycle.
